bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial converter that feeds the single-bit `d` input of the serial pattern detector (Moore "1001" detector) one bit per clock. It accepts words over a valid/ready handshake, buffers one word in a holding register so consecutive words stream without gaps, and drives a constant 0 when it has no data, so the detector always sees a defined bit.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 transmits bit `WIDTH-1` first; 0 transmits bit 0 first.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept `din` this cycle.
- `sout`  out  1  serial bit; connects to detector `d`.
- `sout_valid`  out  1  `sout` carries a data bit (not idle fill).
- `busy`  out  1  shift in progress or holding register occupied.

## Operation
- Registers:
  - `hold_q[WIDTH-1:0]` and `hold_full`: one-deep holding buffer.
  - `shreg[WIDTH-1:0]`: shift register.
  - `cnt`: `$clog2(WIDTH)` bits, counts bits remaining minus 1.
  - `state`: IDLE or SHIFT.
- Outputs:
  - `din_ready = rst_n & ~hold_full`.
  - Handshake: a transfer occurs on any edge where `din_valid & din_ready`. The transfer sets `hold_q <= din` and `hold_full <= 1`. `din` is ignored when `din_ready` is 0.
  - `sout_valid = (state == SHIFT)`.
  - `sout = sout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])`. Idle fill is 0.
  - `busy = (state == SHIFT) | hold_full`.
- IDLE:
  - If `hold_full`: load `shreg <= hold_q`, set `cnt <= WIDTH-1`, clear `hold_full`, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT:
  - Each edge shifts `shreg` one position toward the emitted end. Zero is shifted in. `cnt` decrements.
  - On the edge where `cnt == 0` (last bit):
    - If `hold_full`, reload exactly as in IDLE and stay in SHIFT. This gives a gapless stream.
    - Otherwise go to IDLE.
- Simultaneous load and accept: a new transfer cannot coincide with a load, because `din_ready` is 0 whenever `hold_full` is 1. The holding register is refilled no earlier than the cycle after it empties.
- Reset: when `rst_n` is 0 at an edge:
  - `state <= IDLE`, `hold_full <= 0`, `shreg <= 0`, `cnt <= 0`, `hold_q <= 0`.
  - Any word in flight or held is discarded.
  - Reset values of outputs: `sout = 0`, `sout_valid = 0`, `busy = 0`, `din_ready = 0` while reset is asserted.

## Timing
- Latency: for a word accepted at edge k with the block idle:
  - Load happens at edge k+1.
  - The first bit is on `sout` in the cycle after edge k+1.
  - The last bit is in the cycle after edge k+WIDTH.
- Throughput: one bit per cycle sustained. The gapless condition is that the next word is transferred at least one cycle before the current word's last-bit cycle. `din_ready` reasserts the cycle after each load, which leaves WIDTH-1 cycles of slack.
- The detector samples `sout` on the same `clk`. The serializer does not look at the detector's output.
- `din_ready` depends combinationally only on registers and `rst_n`, never on `din_valid`.

## Structure
- Shared package holds:
  - State encoding: `SER_IDLE = 1'b0`, `SER_SHIFT = 1'b1`.
  - Default `WIDTH` constant, shared with the detector test harness.
- Single module. The holding register is small enough to stay inline, so there is no sub-module.

## Test plan
- Single word: reset, then send `din=8'h90`. Expected `sout` = 1,0,0,1,0,0,0,0 over 8 cycles with `sout_valid` high throughout. The downstream detector asserts `dout` exactly once.
- Back-to-back: send `8'hA5`, then `8'h3C` as soon as `din_ready` rises. Expected: 16 contiguous `sout_valid` cycles carrying 10100101 00111100, and `busy` high throughout.
- Backpressure: hold `din_valid` high with a stream of 3 words. Each transfer happens only on cycles where `din_ready` is 1. No word is lost or duplicated, and the bit order is exact.
- Idle: no input for 20 cycles after reset. Expected `sout = 0`, `sout_valid = 0`, `busy = 0`, and `din_ready = 1` throughout.
- Reset mid-word: drop `rst_n` after 3 bits of `8'hFF`. The next cycle shows `sout_valid = 0` and `busy = 0`, and no further bits of that word appear after reset is released.
- Parameter variant: `WIDTH=4`, `MSB_FIRST=0`, `din=4'b1001`. Expected `sout` = 1,0,0,1 (LSB first), then idle.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the detector test harness.
package bit_serializer_pkg;

  // Serializer control states; the encoding is fixed so harness probes stay valid.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Default word width, also used by the detector test harness.
  localparam int unsigned SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a single-bit pattern detector.
// One-deep holding register lets consecutive words stream without gaps.
// The serial output is forced to 0 whenever no data bit is being sent.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_e       state;
  ser_state_e       state_next;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  assign din_ready = rst_n & ~hold_full;
  assign accept    = din_valid & din_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SER_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load decision; a load moves the held word into the shifter.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      SER_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt == '0) begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_next = SER_IDLE;
          end
        end
      end
      default: begin
        state_next = SER_IDLE;
      end
    endcase
  end

  // Holding buffer: filled by a handshake, emptied by a load. Both cannot
  // happen on the same edge because din_ready is low while the buffer is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= din;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Shift register and remaining-bit counter; zeros enter at the far end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= hold_q;
      cnt   <= CNT_LAST;
    end else if (state == SER_SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt - 1'b1;
    end
  end

  assign sout_valid = (state == SER_SHIFT);
  assign sout       = sout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign busy       = (state == SER_SHIFT) | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an 8-bit MSB-first and a 4-bit
// LSB-first instance, compared every cycle against a queue-based model.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din8;
  logic       v8;
  logic [3:0] din4;
  logic       v4;

  logic ready8, sout8, svld8, busy8;
  logic ready4, sout4, svld4, busy4;

  int unsigned n_cmp;
  int unsigned n_err;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(v8),
    .din_ready(ready8), .sout(sout8), .sout_valid(svld8), .busy(busy8)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(v4),
    .din_ready(ready4), .sout(sout4), .sout_valid(svld4), .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pending word plus a queue of bits still to appear on sout.
  // The queue head is the bit visible during the current cycle.
  bit         strm [2][$];
  bit         held [2];
  logic [7:0] hword[2];
  int         wdt  [2] = '{8, 4};
  bit         msbf [2] = '{1'b1, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] dn;
      bit         vl;
      bit         acc;
      dn = (i == 0) ? din8 : {4'b0, din4};
      vl = (i == 0) ? v8 : v4;
      if (!rst_n) begin
        strm[i].delete();
        held[i] = 1'b0;
      end else begin
        acc = vl && !held[i];
        if (strm[i].size() > 0) void'(strm[i].pop_front());
        if (strm[i].size() == 0 && held[i]) begin
          for (int b = 0; b < wdt[i]; b++)
            strm[i].push_back(msbf[i] ? hword[i][wdt[i]-1-b] : hword[i][b]);
          held[i] = 1'b0;
        end
        if (acc) begin
          held[i]  = 1'b1;
          hword[i] = dn;
        end
      end
    end
  end

  // Behavioural 1001 detector on the 8-bit instance's serial line.
  logic [3:0] hist;
  int         det_cnt;

  always @(negedge clk) begin
    bit e_sv;
    bit e_so;
    e_sv = strm[0].size() > 0;
    e_so = e_sv ? strm[0][0] : 1'b0;
    check("w8_sout_valid", {31'd0, svld8}, {31'd0, e_sv});
    check("w8_sout",       {31'd0, sout8}, {31'd0, e_so});
    check("w8_busy",       {31'd0, busy8}, {31'd0, (e_sv | held[0])});
    check("w8_din_ready",  {31'd0, ready8}, {31'd0, (rst_n & !held[0])});
    e_sv = strm[1].size() > 0;
    e_so = e_sv ? strm[1][0] : 1'b0;
    check("w4_sout_valid", {31'd0, svld4}, {31'd0, e_sv});
    check("w4_sout",       {31'd0, sout4}, {31'd0, e_so});
    check("w4_busy",       {31'd0, busy4}, {31'd0, (e_sv | held[1])});
    check("w4_din_ready",  {31'd0, ready4}, {31'd0, (rst_n & !held[1])});
    hist = {hist[2:0], sout8};
    if (hist == 4'b1001) det_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present a word and hold valid until the model says it was taken.
  task automatic send(input int idx, input logic [7:0] w);
    bit taken;
    bit acc_now;
    taken = 1'b0;
    if (idx == 0) begin din8 = w; v8 = 1'b1; end
    else begin din4 = w[3:0]; v4 = 1'b1; end
    for (int c = 0; c < 64 && !taken; c++) begin
      acc_now = !held[idx];
      tick(1);
      taken = acc_now;
    end
    if (!taken) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; hist = '0; det_cnt = 0;
    rst_n = 1'b0; din8 = '0; v8 = 1'b0; din4 = '0; v4 = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Idle after reset.
    tick(20);

    // Single word 0x90: detector should fire once.
    det_cnt = 0;
    send(0, 8'h90);
    v8 = 1'b0;
    tick(12);
    check("det_1001_once", det_cnt, 32'd1);

    // Back-to-back words.
    send(0, 8'hA5);
    send(0, 8'h3C);
    v8 = 1'b0;
    tick(20);

    // Backpressure: valid held high across three words.
    for (int k = 0; k < 3; k++) send(0, 8'($urandom));
    v8 = 1'b0;
    tick(30);

    // Reset after three bits of 0xFF.
    send(0, 8'hFF);
    v8 = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);

    // Narrow LSB-first instance.
    send(1, 8'h09);
    v4 = 1'b0;
    tick(8);

    // Random traffic with occasional resets; din also changes while not ready.
    for (int c = 0; c < 600; c++) begin
      v8    = ($urandom_range(3) != 0);
      v4    = ($urandom_range(1) != 0);
      din8  = 8'($urandom);
      din4  = 4'($urandom);
      rst_n = ($urandom_range(79) != 0);
      tick(1);
    end
    v8 = 1'b0; v4 = 1'b0; rst_n = 1'b1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
